reg_file_mp: RTL and testbench

//  Parametrised multi-port register file, successor to the single-write / dual-read file.
//  N read ports, two write ports (ALU result, base-address writeback) and a per-register busy scoreboard.
//  The top index is the PC alias and always reads the external r15 value.

---
 rtl/reg_file_mp.sv | 112 +++++++++++
 tb/tb_reg_file_mp.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD async read ports, two write ports, per-register busy
// scoreboard; top index aliases the external PC. Optional same-cycle bypass: RF_BYPASS_EN.
module reg_file_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned NUM_RD = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          wa0,
    input  logic [DATA_W-1:0]          wd0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          wa1,
    input  logic [DATA_W-1:0]          wd1,
    input  logic [NUM_RD*ADDR_W-1:0]   ra,
    input  logic [DATA_W-1:0]          r15,
    output logic [NUM_RD*DATA_W-1:0]   rd,
    input  logic                       bset,
    input  logic [ADDR_W-1:0]          bset_a,
    output logic [NUM_RD-1:0]          rd_busy,
    output logic [2**ADDR_W-1:0]       busy_vec
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;
    localparam int unsigned NumPhys = NumRegs - 1;
    localparam logic [ADDR_W-1:0] PcIdx = ADDR_W'(NumRegs - 1);

    logic [DATA_W-1:0]  rf_q [NumPhys];
    logic [DATA_W-1:0]  rf_d [NumPhys];
    logic [NumPhys-1:0] busy_q;
    logic [NumPhys-1:0] busy_d;

    // Writes aimed at the PC alias are dropped before they reach the array.
    logic wr0_ok;
    logic wr1_ok;
    assign wr0_ok = we0 && (wa0 != PcIdx);
    assign wr1_ok = we1 && (wa1 != PcIdx);

    // Port 1 is applied first so a same-address port 0 write overrides it.
    always_comb begin
        rf_d = rf_q;
        for (int i = 0; i < int'(NumPhys); i++) begin
            if (wr1_ok && (wa1 == ADDR_W'(i))) begin
                rf_d[i] = wd1;
            end
            if (wr0_ok && (wa0 == ADDR_W'(i))) begin
                rf_d[i] = wd0;
            end
        end
    end

    // Clear on writeback, then set on issue so a new producer stays pending.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < int'(NumPhys); i++) begin
            if ((wr0_ok && (wa0 == ADDR_W'(i))) || (wr1_ok && (wa1 == ADDR_W'(i)))) begin
                busy_d[i] = 1'b0;
            end
            if (bset && (bset_a == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_q   <= '{default: '0};
            busy_q <= '0;
        end else begin
            rf_q   <= rf_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = {1'b0, busy_q};

    for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              busy;

        assign addr = ra[k*ADDR_W +: ADDR_W];

        // The PC alias is served even while reset is held.
        always_comb begin
            data = '0;
            busy = 1'b0;
            if (addr == PcIdx) begin
                data = r15;
            end else if (!rst) begin
`ifdef RF_BYPASS_EN
                if (wr0_ok && (wa0 == addr)) begin
                    data = wd0;
                end else if (wr1_ok && (wa1 == addr)) begin
                    data = wd1;
                end else begin
                    data = rf_q[addr];
                    busy = busy_q[addr];
                end
`else
                data = rf_q[addr];
                busy = busy_q[addr];
`endif
            end
        end

        assign rd[k*DATA_W +: DATA_W] = data;
        assign rd_busy[k]             = busy;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default-size instance plus a DATA_W=16/ADDR_W=3/NUM_RD=2 one,
// expectations queued as stimulus is driven and popped when outputs are sampled.
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 3;
`ifdef RF_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             we0, we1, bset;
    logic [AW-1:0]    wa0, wa1, bset_a;
    logic [DW-1:0]    wd0, wd1, r15;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rd_busy;
    logic [2**AW-1:0] busy_vec;

    logic        s_we0, s_we1, s_bset;
    logic [2:0]  s_wa0, s_wa1, s_bset_a;
    logic [15:0] s_wd0, s_wd1, s_r15;
    logic [5:0]  s_ra;
    logic [31:0] s_rd;
    logic [1:0]  s_rd_busy;
    logic [7:0]  s_busy_vec;

    assign s_r15 = r15[15:0];

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk(clk), .rst(rst),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .r15(r15), .rd(rd),
        .bset(bset), .bset_a(bset_a),
        .rd_busy(rd_busy), .busy_vec(busy_vec)
    );

    reg_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2)) dut_s (
        .clk(clk), .rst(rst),
        .we0(s_we0), .wa0(s_wa0), .wd0(s_wd0),
        .we1(s_we1), .wa1(s_wa1), .wd1(s_wd1),
        .ra(s_ra), .r15(s_r15), .rd(s_rd),
        .bset(s_bset), .bset_a(s_bset_a),
        .rd_busy(s_rd_busy), .busy_vec(s_busy_vec)
    );

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [63:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic pop_check(input logic [63:0] obs);
        exp_t x;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0h required a queued expectation", obs);
            return;
        end
        x = sb.pop_front();
        assert (obs === x.exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", x.tag, obs, x.exp);
        end
    endtask

    function automatic logic [DW-1:0] rdk(input int k);
        return rd[k*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; bset = 0;
        s_we0 = 0; s_we1 = 0; s_bset = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; idle();
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; bset_a = '0;
        s_wa0 = '0; s_wa1 = '0; s_wd0 = '0; s_wd1 = '0; s_bset_a = '0; s_ra = '0;
        r15 = 32'h100;
        ra = {4'd15, 4'd1, 4'd0};
        #1;
        push("rst_rd0", 0);             pop_check(rdk(0));
        push("rst_rd1", 0);             pop_check(rdk(1));
        push("rst_rd2_pc", 32'h100);    pop_check(rdk(2));
        push("rst_busy_vec", 0);        pop_check(busy_vec);
        push("rst_rd_busy", 0);         pop_check(rd_busy);
        tick(); tick();
        rst = 0;

        // Async reset mid-run wipes r3 and the scoreboard.
        we0 = 1; wa0 = 4'd3; wd0 = 32'h12345678; bset = 1; bset_a = 4'd5;
        tick(); idle();
        ra[3:0] = 4'd3;
        #1;
        push("pre_rst_r3", 32'h12345678); pop_check(rdk(0));
        push("pre_rst_busy", 64'h20);     pop_check(busy_vec);
        #2 rst = 1;
        #1;
        push("async_rst_rd0", 0);   pop_check(rdk(0));
        push("async_rst_busy", 0);  pop_check(busy_vec);
        tick(); rst = 0;

        // Same-address dual write: port 0 wins.
        we0 = 1; wa0 = 4'd2; wd0 = 32'hAAAA0000;
        we1 = 1; wa1 = 4'd2; wd1 = 32'h00005555;
        ra[7:4] = 4'd2;
        #1;
        push("dual_wr_same_cycle", Byp ? 64'hAAAA0000 : 64'h0); pop_check(rdk(1));
        tick(); idle();
        #1;
        push("dual_wr_port0_wins", 32'hAAAA0000); pop_check(rdk(1));

        // PC writes dropped; PC reads follow r15 and are never busy.
        we0 = 1; wa0 = 4'd15; wd0 = 32'hDEADBEEF; r15 = 32'h108;
        bset = 1; bset_a = 4'd15; ra[3:0] = 4'd15;
        tick(); idle();
        #1;
        push("pc_read", 32'h108);      pop_check(rdk(0));
        push("pc_rd_busy", 0);         pop_check(rd_busy[0]);
        push("pc_busy_vec", 0);        pop_check(busy_vec);
        r15 = 32'h200;
        #1;
        push("pc_read_follow", 32'h200); pop_check(rdk(0));

        // Scoreboard set, set-beats-clear, clear.
        bset = 1; bset_a = 4'd4; ra[3:0] = 4'd4;
        tick(); idle();
        #1;
        push("busy_set_port", 1);      pop_check(rd_busy[0]);
        push("busy_set_vec", 64'h10);  pop_check(busy_vec);
        we1 = 1; wa1 = 4'd4; wd1 = 32'h44; bset = 1; bset_a = 4'd4;
        tick(); idle();
        #1;
        push("set_wins_vec", 64'h10);  pop_check(busy_vec);
        push("set_wins_port", 1);      pop_check(rd_busy[0]);
        push("wr1_data", 32'h44);      pop_check(rdk(0));
        we0 = 1; wa0 = 4'd4; wd0 = 32'h4040;
        tick(); idle();
        #1;
        push("clear_vec", 0);          pop_check(busy_vec);
        push("clear_port", 0);         pop_check(rd_busy[0]);
        push("wr0_data", 32'h4040);    pop_check(rdk(0));

        // Same-cycle write/read visibility on port 2.
        bset = 1; bset_a = 4'd7;
        tick(); idle();
        we0 = 1; wa0 = 4'd7; wd0 = 32'h77; ra[11:8] = 4'd7;
        #1;
        push("bypass_rd2", Byp ? 64'h77 : 64'h0);  pop_check(rdk(2));
        push("bypass_busy2", Byp ? 64'h0 : 64'h1); pop_check(rd_busy[2]);
        tick(); idle();
        #1;
        push("next_cycle_rd2", 32'h77); pop_check(rdk(2));
        push("next_cycle_busy2", 0);    pop_check(rd_busy[2]);

        // Small instance: r0..r6 written with their index, odd ones via port 1.
        for (int i = 0; i < 7; i++) begin
            idle();
            if (i % 2 == 1) begin
                s_we1 = 1; s_wa1 = 3'(i); s_wd1 = 16'(i);
            end else begin
                s_we0 = 1; s_wa0 = 3'(i); s_wd0 = 16'(i);
            end
            tick();
        end
        idle();
        for (int i = 0; i < 7; i++) begin
            s_ra = {3'(6 - i), 3'(i)};
            #1;
            push($sformatf("small_rd0_r%0d", i), 64'(i));     pop_check(s_rd[15:0]);
            push($sformatf("small_rd1_r%0d", 6 - i), 64'(6 - i)); pop_check(s_rd[31:16]);
        end
        r15 = 32'h1234BEEF;
        s_ra = {3'd7, 3'd7};
        #1;
        push("small_pc_rd0", 16'hBEEF); pop_check(s_rd[15:0]);
        push("small_pc_rd1", 16'hBEEF); pop_check(s_rd[31:16]);
        push("small_busy_vec", 0);      pop_check(s_busy_vec);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
